vram_arbiter: RTL and testbench

Single-port VRAM arbiter that shares the frame-buffer memory between three requesters: display scanout reads, GPU rasterizer pixel writes, and Wishbone host reads/writes. It sits between the rasterizer/VRAM control path and the external VRAM port, buffering GPU pixel writes in a small FIFO so the rasterizer does not stall on short display bursts. One VRAM access is issued per cycle at most; VRAM read data returns one cycle after the access.

---
 rtl/vram_arbiter_if.sv | 61 ++++++
 rtl/vram_arbiter.sv | 224 ++++++++++++++++++++++
 tb/tb_vram_arbiter.sv | 334 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vram_arbiter_if.sv
// vram_arbiter_if: bundles the display, GPU, host and VRAM-port signals of
// the VRAM arbiter. The arbiter uses the slave modport; whatever drives the
// requesters and models the VRAM uses the master modport.
interface vram_arbiter_if #(
    parameter int ADDR_W = 18,
    parameter int DATA_W = 16
);
    // display scanout read port
    logic              disp_req_i;
    logic [ADDR_W-1:0] disp_addr_i;
    logic              disp_gnt_o;
    logic              disp_rvalid_o;
    logic [DATA_W-1:0] disp_rdata_o;

    // GPU rasterizer pixel write port
    logic              gpu_wr_i;
    logic [ADDR_W-1:0] gpu_addr_i;
    logic [DATA_W-1:0] gpu_data_i;
    logic              gpu_full_o;
    logic              gpu_ovf_o;

    // Wishbone host port
    logic              host_req_i;
    logic              host_we_i;
    logic [ADDR_W-1:0] host_addr_i;
    logic [DATA_W-1:0] host_wdata_i;
    logic              host_ack_o;
    logic [DATA_W-1:0] host_rdata_o;

    // external VRAM port and status
    logic              vram_en_o;
    logic              vram_we_o;
    logic [ADDR_W-1:0] vram_addr_o;
    logic [DATA_W-1:0] vram_wdata_o;
    logic [DATA_W-1:0] vram_rdata_i;
    logic              busy_o;

    modport slave (
        input  disp_req_i, disp_addr_i,
        input  gpu_wr_i, gpu_addr_i, gpu_data_i,
        input  host_req_i, host_we_i, host_addr_i, host_wdata_i,
        input  vram_rdata_i,
        output disp_gnt_o, disp_rvalid_o, disp_rdata_o,
        output gpu_full_o, gpu_ovf_o,
        output host_ack_o, host_rdata_o,
        output vram_en_o, vram_we_o, vram_addr_o, vram_wdata_o,
        output busy_o
    );

    modport master (
        output disp_req_i, disp_addr_i,
        output gpu_wr_i, gpu_addr_i, gpu_data_i,
        output host_req_i, host_we_i, host_addr_i, host_wdata_i,
        output vram_rdata_i,
        input  disp_gnt_o, disp_rvalid_o, disp_rdata_o,
        input  gpu_full_o, gpu_ovf_o,
        input  host_ack_o, host_rdata_o,
        input  vram_en_o, vram_we_o, vram_addr_o, vram_wdata_o,
        input  busy_o
    );
endinterface

// File: rtl/vram_arbiter.sv
// vram_arbiter: shares a single-port frame-buffer VRAM between display
// scanout reads, buffered GPU pixel writes and Wishbone host accesses.
// Display always wins. GPU vs host is fixed priority (GPU first) unless the
// VRAM_ARB_RR_EN macro is defined, which makes them alternate round-robin.
// VRAM reads return data one cycle after the strobe; a registered tag steers
// that data to the requester that issued it.
module vram_arbiter #(
    parameter int ADDR_W     = 18,
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 4
) (
    input logic          wb_clk_i,
    input logic          wb_rst_ni,
    vram_arbiter_if.slave bus
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        TAG_NONE = 2'b00,
        TAG_DISP = 2'b01,
        TAG_HOST = 2'b10
    } rd_tag_e;

    typedef enum logic [1:0] {
        OWN_NONE = 2'b00,
        OWN_DISP = 2'b01,
        OWN_GPU  = 2'b10,
        OWN_HOST = 2'b11
    } owner_e;

    // GPU write FIFO storage (contents need no reset; count/pointers do)
    logic [ADDR_W-1:0] fifo_addr_mem [FIFO_DEPTH];
    logic [DATA_W-1:0] fifo_data_mem [FIFO_DEPTH];

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              ovf_q, ovf_d;
    logic              host_out_q, host_out_d;
    logic              vram_en_q, vram_en_d;
    logic              vram_we_q, vram_we_d;
    logic [ADDR_W-1:0] vram_addr_q, vram_addr_d;
    logic [DATA_W-1:0] vram_wdata_q, vram_wdata_d;
    rd_tag_e           rd_tag_q, rd_tag_d;
    logic              disp_rvalid_q, disp_rvalid_d;
    logic              host_ack_q, host_ack_d;
    logic              host_rd_ack_q, host_rd_ack_d;
`ifdef VRAM_ARB_RR_EN
    logic              rr_host_next_q, rr_host_next_d;
`endif

    logic   fifo_empty;
    logic   fifo_full;
    logic   push;
    logic   pop;
    logic   gpu_elig;
    logic   host_elig;
    owner_e owner;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
    assign push       = bus.gpu_wr_i & ~fifo_full;
    assign pop        = (owner == OWN_GPU);
    assign gpu_elig   = ~fifo_empty;
    assign host_elig  = bus.host_req_i & ~host_out_q;

    // Pick this cycle's VRAM owner: display first, then GPU vs host.
    always_comb begin
        owner = OWN_NONE;
        if (bus.disp_req_i) begin
            owner = OWN_DISP;
        end
`ifdef VRAM_ARB_RR_EN
        else if (gpu_elig && host_elig) begin
            owner = rr_host_next_q ? OWN_HOST : OWN_GPU;
        end
`endif
        else if (gpu_elig) begin
            owner = OWN_GPU;
        end else if (host_elig) begin
            owner = OWN_HOST;
        end
    end

    // Next-state for FIFO bookkeeping, VRAM port, read tracking and acks.
    always_comb begin
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        ovf_d         = ovf_q;
        host_out_d    = host_out_q;
        vram_en_d     = 1'b0;
        vram_we_d     = vram_we_q;
        vram_addr_d   = vram_addr_q;
        vram_wdata_d  = vram_wdata_q;
        rd_tag_d      = TAG_NONE;
        disp_rvalid_d = (rd_tag_q == TAG_DISP);
        host_rd_ack_d = (rd_tag_q == TAG_HOST);
        host_ack_d    = (rd_tag_q == TAG_HOST);
`ifdef VRAM_ARB_RR_EN
        rr_host_next_d = rr_host_next_q;
`endif

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        if (bus.gpu_wr_i && fifo_full) begin
            ovf_d = 1'b1;
        end

        if (host_ack_q) begin
            host_out_d = 1'b0;
        end

        case (owner)
            OWN_DISP: begin
                vram_en_d   = 1'b1;
                vram_we_d   = 1'b0;
                vram_addr_d = bus.disp_addr_i;
                rd_tag_d    = TAG_DISP;
            end
            OWN_GPU: begin
                vram_en_d    = 1'b1;
                vram_we_d    = 1'b1;
                vram_addr_d  = fifo_addr_mem[rd_ptr_q];
                vram_wdata_d = fifo_data_mem[rd_ptr_q];
`ifdef VRAM_ARB_RR_EN
                rr_host_next_d = 1'b1;
`endif
            end
            OWN_HOST: begin
                vram_en_d   = 1'b1;
                vram_we_d   = bus.host_we_i;
                vram_addr_d = bus.host_addr_i;
                host_out_d  = 1'b1;
                if (bus.host_we_i) begin
                    vram_wdata_d = bus.host_wdata_i;
                    host_ack_d   = 1'b1;
                end else begin
                    rd_tag_d = TAG_HOST;
                end
`ifdef VRAM_ARB_RR_EN
                rr_host_next_d = 1'b0;
`endif
            end
            default: begin
            end
        endcase
    end

    // Register all arbiter state; reset drops in-flight reads and the FIFO.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            ovf_q         <= 1'b0;
            host_out_q    <= 1'b0;
            vram_en_q     <= 1'b0;
            vram_we_q     <= 1'b0;
            vram_addr_q   <= '0;
            vram_wdata_q  <= '0;
            rd_tag_q      <= TAG_NONE;
            disp_rvalid_q <= 1'b0;
            host_ack_q    <= 1'b0;
            host_rd_ack_q <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            ovf_q         <= ovf_d;
            host_out_q    <= host_out_d;
            vram_en_q     <= vram_en_d;
            vram_we_q     <= vram_we_d;
            vram_addr_q   <= vram_addr_d;
            vram_wdata_q  <= vram_wdata_d;
            rd_tag_q      <= rd_tag_d;
            disp_rvalid_q <= disp_rvalid_d;
            host_ack_q    <= host_ack_d;
            host_rd_ack_q <= host_rd_ack_d;
        end
    end

`ifdef VRAM_ARB_RR_EN
    // Round-robin pointer starts with GPU next and flips on GPU/host grants.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            rr_host_next_q <= 1'b0;
        end else begin
            rr_host_next_q <= rr_host_next_d;
        end
    end
`endif

    // Write accepted pixels into the FIFO slot at the write pointer.
    always_ff @(posedge wb_clk_i) begin
        if (push) begin
            fifo_addr_mem[wr_ptr_q] <= bus.gpu_addr_i;
            fifo_data_mem[wr_ptr_q] <= bus.gpu_data_i;
        end
    end

    // Display grant is gated by reset so every output reads 0 while held.
    assign bus.disp_gnt_o    = bus.disp_req_i & wb_rst_ni;
    assign bus.disp_rvalid_o = disp_rvalid_q;
    assign bus.disp_rdata_o  = disp_rvalid_q ? bus.vram_rdata_i : '0;
    assign bus.host_ack_o    = host_ack_q;
    assign bus.host_rdata_o  = host_rd_ack_q ? bus.vram_rdata_i : '0;
    assign bus.gpu_full_o    = fifo_full;
    assign bus.gpu_ovf_o     = ovf_q;
    assign bus.vram_en_o     = vram_en_q;
    assign bus.vram_we_o     = vram_we_q;
    assign bus.vram_addr_o   = vram_addr_q;
    assign bus.vram_wdata_o  = vram_wdata_q;
    assign bus.busy_o        = ~fifo_empty | host_out_q | (rd_tag_q != TAG_NONE)
                             | disp_rvalid_q | host_rd_ack_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: drives directed and random traffic into vram_arbiter,
// predicts every VRAM strobe, host ack and display return with a queue-based
// reference model, and compares them in a separate monitor process.
module tb_vram_arbiter;

    localparam int ADDR_W = 18;
    localparam int DATA_W = 16;
    localparam int DEPTH  = 4;

    logic wb_clk_i  = 1'b0;
    logic wb_rst_ni = 1'b1;

    vram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    vram_arbiter #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .wb_clk_i (wb_clk_i),
        .wb_rst_ni(wb_rst_ni),
        .bus      (bus)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    typedef struct {
        int                stamp;
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } exp_t;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } pix_t;

    exp_t exp_vram[$];
    exp_t exp_host[$];
    exp_t exp_disp[$];
    pix_t m_fifo[$];
    logic [DATA_W-1:0] m_mem [int];
    logic [DATA_W-1:0] v_mem [int];
    bit m_host_out;
    bit m_rr_host_next;
    bit m_ovf;
    int m_host_clear_at;
    int ncyc  = 0;
    int n_vec = 0;
    int n_err = 0;

    // Power-on content of the VRAM for words never written.
    function automatic logic [DATA_W-1:0] initContent(input logic [ADDR_W-1:0] a);
        logic [DATA_W-1:0] lo;
        lo = a[DATA_W-1:0];
        return lo ^ 16'h5A3C;
    endfunction

    function automatic logic [DATA_W-1:0] modelRead(input logic [ADDR_W-1:0] a);
        if (m_mem.exists(int'(a))) return m_mem[int'(a)];
        return initContent(a);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, expv, ncyc);
        end
    endtask

    task automatic modelClear();
        m_fifo.delete();
        exp_vram.delete();
        exp_host.delete();
        exp_disp.delete();
        m_host_out     = 1'b0;
        m_rr_host_next = 1'b0;
        m_ovf          = 1'b0;
    endtask

    // One arbitration step of the reference model, applied at each rising edge.
    task automatic modelStep();
        int   owner;
        int   size_before;
        bit   gpu_el;
        bit   host_el;
        exp_t e;
        pix_t p;
        size_before = m_fifo.size();
        gpu_el      = (size_before > 0);
        host_el     = bus.host_req_i && !m_host_out;
        owner       = 0;
        if (bus.disp_req_i) owner = 1;
`ifdef VRAM_ARB_RR_EN
        else if (gpu_el && host_el) owner = m_rr_host_next ? 3 : 2;
`endif
        else if (gpu_el) owner = 2;
        else if (host_el) owner = 3;

        if (owner == 1) begin
            e.stamp = ncyc; e.we = 1'b0; e.addr = bus.disp_addr_i; e.data = '0;
            exp_vram.push_back(e);
            e.stamp = ncyc + 1; e.data = modelRead(bus.disp_addr_i);
            exp_disp.push_back(e);
        end else if (owner == 2) begin
            p = m_fifo.pop_front();
            e.stamp = ncyc; e.we = 1'b1; e.addr = p.addr; e.data = p.data;
            exp_vram.push_back(e);
            m_mem[int'(p.addr)] = p.data;
            m_rr_host_next = 1'b1;
        end else if (owner == 3) begin
            e.addr = bus.host_addr_i;
            e.we   = bus.host_we_i;
            e.stamp = ncyc;
            if (bus.host_we_i) begin
                e.data = bus.host_wdata_i;
                exp_vram.push_back(e);
                m_mem[int'(bus.host_addr_i)] = bus.host_wdata_i;
                exp_host.push_back(e);
                m_host_clear_at = ncyc + 1;
            end else begin
                e.data = '0;
                exp_vram.push_back(e);
                e.stamp = ncyc + 1;
                e.data  = modelRead(bus.host_addr_i);
                exp_host.push_back(e);
                m_host_clear_at = ncyc + 2;
            end
            m_host_out     = 1'b1;
            m_rr_host_next = 1'b0;
        end

        if (m_host_out && m_host_clear_at == ncyc) m_host_out = 1'b0;

        if (bus.gpu_wr_i) begin
            if (size_before == DEPTH) begin
                m_ovf = 1'b1;
            end else begin
                p.addr = bus.gpu_addr_i;
                p.data = bus.gpu_data_i;
                m_fifo.push_back(p);
            end
        end
    endtask

    // Reference model advances on every rising edge.
    always @(posedge wb_clk_i) begin
        ncyc++;
        if (!wb_rst_ni) modelClear();
        else modelStep();
    end

    // Behavioural VRAM: writes land at the strobe, reads return next cycle.
    always @(posedge wb_clk_i) begin
        if (bus.vram_en_o) begin
            if (bus.vram_we_o) begin
                v_mem[int'(bus.vram_addr_o)] = bus.vram_wdata_o;
            end else if (v_mem.exists(int'(bus.vram_addr_o))) begin
                bus.vram_rdata_i <= v_mem[int'(bus.vram_addr_o)];
            end else begin
                bus.vram_rdata_i <= initContent(bus.vram_addr_o);
            end
        end
    end

    // Monitor: on each falling edge compare DUT outputs with queued expectations.
    always @(negedge wb_clk_i) begin
        exp_t e;
        if (!wb_rst_ni) begin
            checkOutput("rst_vram_en",   32'(bus.vram_en_o),     32'(0));
            checkOutput("rst_vram_we",   32'(bus.vram_we_o),     32'(0));
            checkOutput("rst_vram_addr", 32'(bus.vram_addr_o),   32'(0));
            checkOutput("rst_vram_wdat", 32'(bus.vram_wdata_o),  32'(0));
            checkOutput("rst_host_ack",  32'(bus.host_ack_o),    32'(0));
            checkOutput("rst_host_rdat", 32'(bus.host_rdata_o),  32'(0));
            checkOutput("rst_disp_rv",   32'(bus.disp_rvalid_o), 32'(0));
            checkOutput("rst_disp_rdat", 32'(bus.disp_rdata_o),  32'(0));
            checkOutput("rst_disp_gnt",  32'(bus.disp_gnt_o),    32'(0));
            checkOutput("rst_full",      32'(bus.gpu_full_o),    32'(0));
            checkOutput("rst_ovf",       32'(bus.gpu_ovf_o),     32'(0));
            checkOutput("rst_busy",      32'(bus.busy_o),        32'(0));
        end else begin
            checkOutput("disp_gnt", 32'(bus.disp_gnt_o), 32'(bus.disp_req_i));
            if (exp_vram.size() > 0 && exp_vram[0].stamp == ncyc) begin
                e = exp_vram.pop_front();
                checkOutput("vram_en",   32'(bus.vram_en_o),   32'(1));
                checkOutput("vram_we",   32'(bus.vram_we_o),   32'(e.we));
                checkOutput("vram_addr", 32'(bus.vram_addr_o), 32'(e.addr));
                if (e.we) checkOutput("vram_wdata", 32'(bus.vram_wdata_o), 32'(e.data));
            end else begin
                checkOutput("vram_en", 32'(bus.vram_en_o), 32'(0));
            end
            if (exp_host.size() > 0 && exp_host[0].stamp == ncyc) begin
                e = exp_host.pop_front();
                checkOutput("host_ack", 32'(bus.host_ack_o), 32'(1));
                if (!e.we) checkOutput("host_rdata", 32'(bus.host_rdata_o), 32'(e.data));
            end else begin
                checkOutput("host_ack", 32'(bus.host_ack_o), 32'(0));
            end
            if (exp_disp.size() > 0 && exp_disp[0].stamp == ncyc) begin
                e = exp_disp.pop_front();
                checkOutput("disp_rvalid", 32'(bus.disp_rvalid_o), 32'(1));
                checkOutput("disp_rdata",  32'(bus.disp_rdata_o),  32'(e.data));
            end else begin
                checkOutput("disp_rvalid", 32'(bus.disp_rvalid_o), 32'(0));
            end
            checkOutput("gpu_full", 32'(bus.gpu_full_o), 32'(m_fifo.size() == DEPTH));
            checkOutput("gpu_ovf",  32'(bus.gpu_ovf_o),  32'(m_ovf));
        end
    end

    // Drive one cycle of inputs; the host request is held until its ack.
    task automatic applyStimulus(input bit d_req, input logic [ADDR_W-1:0] d_addr,
                                 input bit g_wr, input logic [ADDR_W-1:0] g_addr,
                                 input logic [DATA_W-1:0] g_data,
                                 input bit h_start, input bit h_we,
                                 input logic [ADDR_W-1:0] h_addr,
                                 input logic [DATA_W-1:0] h_wdata);
        @(posedge wb_clk_i);
        #1;
        bus.disp_req_i  = d_req;
        bus.disp_addr_i = d_addr;
        bus.gpu_wr_i    = g_wr;
        bus.gpu_addr_i  = g_addr;
        bus.gpu_data_i  = g_data;
        if (bus.host_req_i && bus.host_ack_o) begin
            bus.host_req_i = 1'b0;
        end else if (!bus.host_req_i && h_start) begin
            bus.host_req_i   = 1'b1;
            bus.host_we_i    = h_we;
            bus.host_addr_i  = h_addr;
            bus.host_wdata_i = h_wdata;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, '0, 0, '0, '0, 0, 0, '0, '0);
    endtask

    task automatic randomTraffic(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(($urandom_range(0, 3) == 0), ADDR_W'($urandom_range(0, 15)),
                          ($urandom_range(0, 1) == 1), ADDR_W'($urandom_range(0, 15)),
                          DATA_W'($urandom), ($urandom_range(0, 2) == 0),
                          ($urandom_range(0, 1) == 1), ADDR_W'($urandom_range(0, 15)),
                          DATA_W'($urandom));
        end
    endtask

    // Assert reset in the middle of traffic, hold it, then release it.
    task automatic resetMidTraffic();
        @(posedge wb_clk_i);
        #1;
        wb_rst_ni      = 1'b0;
        bus.host_req_i = 1'b0;
        modelClear();
        for (int i = 0; i < 3; i++) begin
            @(posedge wb_clk_i);
            #1;
            bus.disp_req_i = ($urandom_range(0, 1) == 1);
            bus.gpu_wr_i   = ($urandom_range(0, 1) == 1);
        end
        @(posedge wb_clk_i);
        #1;
        bus.disp_req_i = 1'b0;
        bus.gpu_wr_i   = 1'b0;
        wb_rst_ni      = 1'b1;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bus.disp_req_i   = 1'b0;
        bus.disp_addr_i  = '0;
        bus.gpu_wr_i     = 1'b0;
        bus.gpu_addr_i   = '0;
        bus.gpu_data_i   = '0;
        bus.host_req_i   = 1'b0;
        bus.host_we_i    = 1'b0;
        bus.host_addr_i  = '0;
        bus.host_wdata_i = '0;
        v_mem[32'h20]    = 16'h07E0;
        m_mem[32'h20]    = 16'h07E0;
        #2;
        wb_rst_ni = 1'b0;
        repeat (3) @(posedge wb_clk_i);
        #1;
        wb_rst_ni = 1'b1;
        $display("[TB] reset released");

        // single GPU pixel into an idle arbiter
        applyStimulus(0, '0, 1, 18'h00010, 16'hF800, 0, 0, '0, '0);
        idle(5);

        // host read with a known word in VRAM
        applyStimulus(0, '0, 0, '0, '0, 1, 0, 18'h00020, '0);
        idle(8);

        // display holds the port for 6 cycles while 5 pixels are pushed
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1, ADDR_W'(18'h00100 + i), (i < 5), ADDR_W'(18'h00200 + i),
                          DATA_W'(16'h1000 + i), 0, 0, '0, '0);
        end
        idle(10);

        // three buffered pixels plus a pending host write, then display lets go
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, ADDR_W'(18'h00300 + i), 1, ADDR_W'(18'h00030 + i),
                          DATA_W'(16'h2000 + i), (i == 0), 1, 18'h00040, 16'h1234);
        end
        idle(10);

        $display("[TB] random traffic");
        randomTraffic(300);
        resetMidTraffic();
        idle(3);
        randomTraffic(200);
        idle(30);

        checkOutput("left_vram", 32'(exp_vram.size()), 32'(0));
        checkOutput("left_host", 32'(exp_host.size()), 32'(0));
        checkOutput("left_disp", 32'(exp_disp.size()), 32'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
